// File: rtl/apb_pkg.sv
// Shared APB definitions imported by the AHB-to-APB bridge and its completers.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [APB_DATA_W-1:0] merge_bytes(
    input logic [APB_DATA_W-1:0] old_word,
    input logic [APB_DATA_W-1:0] new_word,
    input logic [APB_STRB_W-1:0] strb
  );
    logic [APB_DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < APB_STRB_W; i++) begin
      if (strb[i]) begin
        result[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        result[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x 32-bit register storage: async-reset words, byte-enable write port,
// registered read port that can be loaded with zero instead of a word.
module apb_mem_array
  import apb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [APB_STRB_W-1:0] be,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [IDX_W-1:0]      raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];
  logic [APB_DATA_W-1:0] mem_d [DEPTH];
  logic [APB_DATA_W-1:0] rdata_q;
  logic [APB_DATA_W-1:0] rdata_d;

  // Next-state of the storage words and the read register.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (we) begin
      mem_d[waddr] = merge_bytes(mem_q[waddr], wdata, be);
    end else begin
      mem_d[waddr] = mem_q[waddr];
    end
    if (re) begin
      rdata_d = rclr ? {APB_DATA_W{1'b0}} : mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage and read register flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {APB_DATA_W{1'b0}};
      end
      rdata_q <= {APB_DATA_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer with a DEPTH-word register array, fixed wait states and PSLVERR
// on bad addresses. Define APB_PSTRB_EN to add the PSTRB byte-lane port.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    DEPTH       = 64,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  BCLK,
  input  logic                  BRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [APB_STRB_W-1:0] PSTRB,
`endif
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                    IDX_W     = $clog2(DEPTH);
  localparam logic [APB_ADDR_W-1:0] SPAN      = APB_ADDR_W'(DEPTH * 4);
  localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_STATES);

  apb_state_t            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [APB_STRB_W-1:0] strb_q, strb_d;

  logic [APB_ADDR_W-1:0] offset;
  logic [IDX_W-1:0]      addr_idx;
  logic                  req_err;
  logic [APB_STRB_W-1:0] req_strb;
  logic                  done;
  logic                  mem_we;
  logic                  mem_re;
  logic [APB_DATA_W-1:0] mem_rdata;

  // Address decode of the live bus; only consumed while in SETUP.
  always_comb begin
    offset   = PADDR - BASE_ADDR;
    addr_idx = offset[IDX_W+1:2];
`ifdef APB_PSTRB_EN
    req_strb = PSTRB;
    req_err  = (PADDR < BASE_ADDR) || (offset >= SPAN) || (PADDR[1:0] != 2'b00) ||
               (!PWRITE && (PSTRB != 4'b0000));
`else
    req_strb = 4'b1111;
    req_err  = (PADDR < BASE_ADDR) || (offset >= SPAN) || (PADDR[1:0] != 2'b00);
`endif
  end

  assign done = (state_q == ACCESS) && (cnt_q == 4'd0);

  // Transfer FSM, wait counter and SETUP-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      IDLE: begin
        // PENABLE without a preceding setup phase is not a transfer.
        if (PSEL && !PENABLE) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        idx_d   = addr_idx;
        write_d = PWRITE;
        err_d   = req_err;
        wdata_d = PWDATA;
        strb_d  = req_strb;
        cnt_d   = WAIT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          if (!PSEL) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else if (PSEL && !PENABLE) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control and capture registers.
  always_ff @(posedge BCLK or posedge BRESET) begin
    if (BRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= {IDX_W{1'b0}};
      write_q <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= {APB_DATA_W{1'b0}};
      strb_q  <= {APB_STRB_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  // Reads are fetched at the end of SETUP so the word is ready on the first ACCESS cycle.
  assign mem_re = (state_q == SETUP) && !PWRITE;
  assign mem_we = done && write_q && !err_q;

  apb_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (BCLK),
    .rst   (BRESET),
    .we    (mem_we),
    .be    (strb_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .re    (mem_re),
    .rclr  (req_err),
    .raddr (addr_idx),
    .rdata (mem_rdata)
  );

  assign PREADY  = done;
  assign PSLVERR = done && err_q;
  assign PRDATA  = ((state_q == ACCESS) && !write_q) ? mem_rdata : {APB_DATA_W{1'b0}};

endmodule
